// File: rtl/axil_sram_ctrl_pkg.sv
// Shared types and constants for the AXI4-Lite to single-port SRAM controller.
// Holds the FSM state encoding, AXI response codes and byte-lane geometry.
package axil_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_RD_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DATA_WIDTH       = 32;
  localparam int BYTE_WIDTH       = 8;
  localparam int BYTE_LANES       = DATA_WIDTH / BYTE_WIDTH;
  localparam int BYTE_OFFSET_BITS = 2;

endpackage

// File: rtl/axil_sram_ctrl.sv
// AXI4-Lite slave driving one single-port OpenRAM macro (posedge latch, negedge update).
// One outstanding transaction; write/read contention is resolved by a toggling priority flag.
module axil_sram_ctrl
  import axil_sram_ctrl_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_WORDS      = 512,
  parameter int MEM_DATA_WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [31:0]               s_axi_wdata,
  input  logic [3:0]                s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,

  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [31:0]               s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,

  output logic                      mem_csb,
  output logic                      mem_web,
  output logic [3:0]                mem_wmask,
  output logic                      mem_spare_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [MEM_DATA_WIDTH-1:0] mem_din,
  input  logic [MEM_DATA_WIDTH-1:0] mem_dout
);

  localparam int IDX_WIDTH  = AXI_ADDR_WIDTH - BYTE_OFFSET_BITS;
  localparam int SPARE_BITS = MEM_DATA_WIDTH - DATA_WIDTH;
  localparam logic [IDX_WIDTH-1:0] WORD_LIMIT = IDX_WIDTH'(MEM_WORDS);

  state_t                state_q, state_d;
  logic                  prio_wr_q;
  logic                  in_range_q;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  wr_pending;
  logic                  contention;
  logic                  grant_wr;
  logic                  grant_rd;

  logic [IDX_WIDTH-1:0]  aw_idx;
  logic [IDX_WIDTH-1:0]  ar_idx;
  logic                  aw_in_range;
  logic                  ar_in_range;

  // The byte offset and the macro spare bit carry no information for this block.
  logic                  unused_ok;
  assign unused_ok = ^{s_axi_awaddr[BYTE_OFFSET_BITS-1:0],
                       s_axi_araddr[BYTE_OFFSET_BITS-1:0],
                       mem_dout[MEM_DATA_WIDTH-1:DATA_WIDTH]};

  assign aw_idx      = s_axi_awaddr[AXI_ADDR_WIDTH-1:BYTE_OFFSET_BITS];
  assign ar_idx      = s_axi_araddr[AXI_ADDR_WIDTH-1:BYTE_OFFSET_BITS];
  assign aw_in_range = aw_idx < WORD_LIMIT;
  assign ar_in_range = ar_idx < WORD_LIMIT;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    contention = 1'b0;
    wr_pending = s_axi_awvalid && s_axi_wvalid;

    case (state_q)
      ST_IDLE: begin
        contention = wr_pending && s_axi_arvalid;
        grant_wr   = wr_pending && (!s_axi_arvalid || prio_wr_q);
        grant_rd   = s_axi_arvalid && !grant_wr;
        if (grant_wr) begin
          state_d = ST_WR_ISSUE;
        end else if (grant_rd) begin
          state_d = ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: state_d = ST_WR_RESP;
      ST_WR_RESP:  if (s_axi_bready) state_d = ST_IDLE;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT:  state_d = ST_RD_RESP;
      ST_RD_RESP:  if (s_axi_rready) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  assign s_axi_awready = grant_wr;
  assign s_axi_wready  = grant_wr;
  assign s_axi_arready = grant_rd;
  assign s_axi_bvalid  = (state_q == ST_WR_RESP);
  assign s_axi_rvalid  = (state_q == ST_RD_RESP);
  assign s_axi_bresp   = resp_q;
  assign s_axi_rresp   = resp_q;
  assign s_axi_rdata   = rdata_q;
  assign mem_spare_wen = 1'b0;

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      prio_wr_q  <= 1'b1;
      in_range_q <= 1'b0;
      resp_q     <= RESP_OKAY;
      rdata_q    <= '0;
      mem_csb    <= 1'b1;
      mem_web    <= 1'b1;
      mem_wmask  <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      state_q <= state_d;
      if (contention) begin
        prio_wr_q <= !prio_wr_q;
      end

      // Strobes default inactive, so a granted access holds the macro for exactly one cycle.
      mem_csb <= 1'b1;
      mem_web <= 1'b1;

      if (grant_wr) begin
        mem_csb    <= !aw_in_range;
        mem_web    <= !aw_in_range;
        mem_wmask  <= s_axi_wstrb;
        mem_addr   <= aw_idx[MEM_ADDR_WIDTH-1:0];
        mem_din    <= {{SPARE_BITS{1'b0}}, s_axi_wdata};
        in_range_q <= aw_in_range;
        resp_q     <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end

      if (grant_rd) begin
        mem_csb    <= !ar_in_range;
        mem_addr   <= ar_idx[MEM_ADDR_WIDTH-1:0];
        in_range_q <= ar_in_range;
        resp_q     <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end

      // The macro drives dout on the negedge inside RD_WAIT; capture it at the closing edge.
      if (state_q == ST_RD_WAIT) begin
        rdata_q <= in_range_q ? mem_dout[DATA_WIDTH-1:0] : '0;
      end
    end
  end

endmodule

// File: tb/tb_axil_sram_ctrl.sv
// Self-checking bench: directed cases plus randomized traffic against a word-array reference
// model, with a behavioural single-port macro (posedge latch, negedge update) behind the DUT.
module tb_axil_sram_ctrl;
  import axil_sram_ctrl_pkg::*;

  localparam int AW  = 32;
  localparam int MAW = 10;
  localparam int MDW = 33;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [AW-1:0]   s_axi_awaddr = '0;
  logic            s_axi_awvalid = 1'b0;
  logic            s_axi_awready;
  logic [31:0]     s_axi_wdata = '0;
  logic [3:0]      s_axi_wstrb = '0;
  logic            s_axi_wvalid = 1'b0;
  logic            s_axi_wready;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid;
  logic            s_axi_bready = 1'b0;
  logic [AW-1:0]   s_axi_araddr = '0;
  logic            s_axi_arvalid = 1'b0;
  logic            s_axi_arready;
  logic [31:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rvalid;
  logic            s_axi_rready = 1'b0;
  logic            mem_csb;
  logic            mem_web;
  logic [3:0]      mem_wmask;
  logic            mem_spare_wen;
  logic [MAW-1:0]  mem_addr;
  logic [MDW-1:0]  mem_din;
  logic [MDW-1:0]  mem_dout = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axil_sram_ctrl #(
    .AXI_ADDR_WIDTH(AW),
    .MEM_ADDR_WIDTH(MAW),
    .MEM_WORDS(512),
    .MEM_DATA_WIDTH(MDW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_csb(mem_csb), .mem_web(mem_web), .mem_wmask(mem_wmask), .mem_spare_wen(mem_spare_wen),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Behavioural macro: inputs latched on posedge, array/dout updated on the following negedge.
  logic [MDW-1:0] sram [0:1023];
  logic           csb_l = 1'b1;
  logic           web_l = 1'b1;
  logic [3:0]     wmask_l = '0;
  logic [MAW-1:0] addr_l = '0;
  logic [MDW-1:0] din_l = '0;

  initial for (int i = 0; i < 1024; i++) sram[i] = '0;

  always @(posedge clk) begin
    csb_l   <= mem_csb;
    web_l   <= mem_web;
    wmask_l <= mem_wmask;
    addr_l  <= mem_addr;
    din_l   <= mem_din;
  end

  always @(negedge clk) begin
    if (!csb_l) begin
      if (!web_l) begin
        for (int b = 0; b < 4; b++)
          if (wmask_l[b]) sram[addr_l][8*b +: 8] <= din_l[8*b +: 8];
      end else begin
        mem_dout <= sram[addr_l];
      end
    end
  end

  int csb_lows = 0;
  always @(negedge clk) if (mem_csb === 1'b0) csb_lows++;

  // Reference model: word array plus the arbitration flag.
  logic [31:0] ref_mem [0:511];
  bit          ref_prio_wr = 1'b1;
  initial for (int i = 0; i < 512; i++) ref_mem[i] = '0;

  function automatic bit in_rng(input logic [31:0] a);
    return (a / 4) < 512;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    if ($urandom_range(0, 7) == 0) a = ($urandom_range(512, 4095) * 4) + $urandom_range(0, 3);
    else a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
    return a;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_hs(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (is_wr ? s_axi_awready : s_axi_arready) begin
        if (is_wr) check("aw_w_ready_together", s_axi_wready, 1);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check(is_wr ? "aw_hs_timeout" : "ar_hs_timeout", 0, 1);
    @(posedge clk); #1;
    if (is_wr) begin
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
    end else begin
      s_axi_arvalid = 1'b0;
    end
  endtask

  task automatic stall_probe(input bit probe, input bit on);
    if (probe) begin
      s_axi_awvalid = on;
      s_axi_wvalid  = on;
      s_axi_arvalid = on;
    end
  endtask

  // Entered in cycle A+1 (just after the handshake edge).
  task automatic write_tail(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int bdelay, input bit probe);
    bit inr;
    int c0;
    inr = in_rng(a);
    c0  = csb_lows;
    @(negedge clk);
    check("wr_a1_csb", mem_csb, !inr);
    if (inr) begin
      check("wr_a1_web", mem_web, 0);
      check("wr_a1_addr", mem_addr, a[11:2]);
      check("wr_a1_wmask", mem_wmask, s);
      check("wr_a1_din", mem_din, {1'b0, d});
    end
    check("wr_a1_bvalid", s_axi_bvalid, 0);
    @(negedge clk);
    check("wr_a2_bvalid", s_axi_bvalid, 1);
    check("wr_bresp", s_axi_bresp, inr ? 2'b00 : 2'b10);
    stall_probe(probe, 1'b1);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge clk);
      check("wr_stall_bvalid", s_axi_bvalid, 1);
      check("wr_stall_bresp", s_axi_bresp, inr ? 2'b00 : 2'b10);
      check("wr_stall_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
      check("wr_stall_csb", mem_csb, 1);
    end
    stall_probe(probe, 1'b0);
    s_axi_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    check("wr_csb_count", csb_lows - c0, inr ? 1 : 0);
    if (inr) ref_mem[a[10:2]] = merge(ref_mem[a[10:2]], d, s);
  endtask

  task automatic read_tail(input logic [31:0] a, input int rdelay, input bit probe,
                           output logic [31:0] data, output logic [1:0] resp);
    bit inr;
    int c0;
    logic [31:0] exp_d;
    inr   = in_rng(a);
    exp_d = inr ? ref_mem[a[10:2]] : 32'h0;
    c0    = csb_lows;
    @(negedge clk);
    check("rd_a1_csb", mem_csb, !inr);
    if (inr) begin
      check("rd_a1_web", mem_web, 1);
      check("rd_a1_addr", mem_addr, a[11:2]);
    end
    check("rd_a1_rvalid", s_axi_rvalid, 0);
    @(negedge clk);
    check("rd_a2_csb", mem_csb, 1);
    check("rd_a2_rvalid", s_axi_rvalid, 0);
    @(negedge clk);
    check("rd_a3_rvalid", s_axi_rvalid, 1);
    check("rd_rdata", s_axi_rdata, exp_d);
    check("rd_rresp", s_axi_rresp, inr ? 2'b00 : 2'b10);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    stall_probe(probe, 1'b1);
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clk);
      check("rd_stall_rvalid", s_axi_rvalid, 1);
      check("rd_stall_rdata", s_axi_rdata, exp_d);
      check("rd_stall_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
      check("rd_stall_csb", mem_csb, 1);
    end
    stall_probe(probe, 1'b0);
    s_axi_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_rready = 1'b0;
    check("rd_csb_count", csb_lows - c0, inr ? 1 : 0);
  endtask

  task automatic write_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int bdelay, input bit probe);
    bit ok;
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
    wait_hs(1'b1, ok);
    if (ok) write_tail(a, d, s, bdelay, probe);
  endtask

  task automatic read_op(input logic [31:0] a, input int rdelay, input bit probe,
                         output logic [31:0] data, output logic [1:0] resp);
    bit ok;
    data = '0;
    resp = 2'b11;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    wait_hs(1'b0, ok);
    if (ok) read_tail(a, rdelay, probe, data, resp);
  endtask

  task automatic pair_op(input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input logic [31:0] ra, output logic [31:0] rd);
    bit exp_w, ok;
    logic [1:0] rr;
    s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = ws;
    s_axi_araddr = ra;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    exp_w = ref_prio_wr;
    ref_prio_wr = !ref_prio_wr;
    check("pair_awready", s_axi_awready, exp_w);
    check("pair_arready", s_axi_arready, !exp_w);
    @(posedge clk); #1;
    if (exp_w) begin
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      write_tail(wa, wd, ws, 0, 1'b0);
      wait_hs(1'b0, ok);
      rd = '0;
      if (ok) read_tail(ra, 0, 1'b0, rd, rr);
    end else begin
      s_axi_arvalid = 1'b0;
      read_tail(ra, 0, 1'b0, rd, rr);
      wait_hs(1'b1, ok);
      if (ok) write_tail(wa, wd, ws, 0, 1'b0);
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr;
    int c0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 0);
    check("rst_valids", {s_axi_bvalid, s_axi_rvalid}, 0);
    check("rst_resps", {s_axi_bresp, s_axi_rresp}, 0);
    check("rst_rdata", s_axi_rdata, 0);
    check("rst_csb_web", {mem_csb, mem_web}, 2'b11);
    check("rst_wmask_addr", {mem_wmask, mem_addr}, 0);
    check("rst_din", mem_din, 0);
    check("rst_spare_wen", mem_spare_wen, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, partial strobes and an empty strobe.
    write_op(32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    read_op(32'h10, 0, 1'b0, rd, rr);
    check("t1_rdata", rd, 32'hDEADBEEF);
    write_op(32'h10, 32'h0000AB00, 4'h2, 0, 1'b0);
    read_op(32'h13, 0, 1'b0, rd, rr);
    check("t2_rdata", rd, 32'hDEADABEF);
    write_op(32'h10, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    read_op(32'h10, 0, 1'b0, rd, rr);
    check("t2_zero_strb_rdata", rd, 32'hDEADABEF);

    // Decode errors at the first unpopulated word.
    write_op(32'h800, 32'h12345678, 4'hF, 0, 1'b0);
    read_op(32'h800, 0, 1'b0, rd, rr);
    check("t3_rdata", rd, 32'h0);
    check("t3_rresp", rr, RESP_SLVERR);
    read_op(32'h7FC, 0, 1'b0, rd, rr);
    check("t3_last_word_resp", rr, RESP_OKAY);

    // Response backpressure with competing requests held high.
    read_op(32'h10, 5, 1'b1, rd, rr);
    write_op(32'h14, 32'h5A5A5A5A, 4'hF, 5, 1'b1);

    // AW without W must never be accepted.
    c0 = csb_lows;
    s_axi_awaddr = 32'h30; s_axi_awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("aw_only_ready", {s_axi_awready, s_axi_wready}, 0);
    end
    s_axi_awvalid = 1'b0;
    @(posedge clk); #1;
    check("aw_only_csb_count", csb_lows - c0, 0);

    // Reset while in RD_WAIT drops the response.
    s_axi_araddr = 32'h14; s_axi_arvalid = 1'b1;
    @(negedge clk);
    check("rst_mid_arready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_rvalid", s_axi_rvalid, 0);
    check("rst_mid_csb", mem_csb, 1);
    check("rst_mid_rdata", s_axi_rdata, 0);
    rst_n = 1'b1;
    ref_prio_wr = 1'b1;
    @(posedge clk); #1;
    read_op(32'h14, 0, 1'b0, rd, rr);
    check("rst_mid_fresh_read", rd, 32'h5A5A5A5A);

    // Contention after reset: write first, then read first.
    pair_op(32'h20, 32'hCAFEF00D, 4'hF, 32'h20, rd);
    check("t4_write_first_rdata", rd, 32'hCAFEF00D);
    pair_op(32'h20, 32'h11223344, 4'hF, 32'h20, rd);
    check("t4_read_first_rdata", rd, 32'hCAFEF00D);
    read_op(32'h20, 0, 1'b0, rd, rr);
    check("t4_final_rdata", rd, 32'h11223344);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: write_op(rand_addr(), $urandom(), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        1: read_op(rand_addr(), $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, rr);
        default: pair_op(rand_addr(), $urandom(), 4'($urandom_range(0, 15)), rand_addr(), rd);
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
